// File: rtl/grey_ptr_decoder_pkg.sv
// Shared constants and helpers for the Gray pointer decoder.
package grey_ptr_decoder_pkg;

  localparam int PTR_WIDTH_DEF   = 5;
  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 2;

  function automatic bit stages_legal(input int n);
    return (n >= PIPE_STAGES_MIN) && (n <= PIPE_STAGES_MAX);
  endfunction

  // Reference Gray-to-binary on a zero-extended 32-bit value.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/grey_ptr_decoder_if.sv
// Sample-in / decoded-pointer-out bundle for grey_ptr_decoder.
// master: pointer source side; slave: the decoder.
interface grey_ptr_decoder_if
  import grey_ptr_decoder_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF
);
  logic [PTR_WIDTH-1:0] grey_in;
  logic                 grey_valid;
  logic                 err_clr;
  logic [PTR_WIDTH-1:0] binary_out;
  logic                 binary_valid;
  logic [PTR_WIDTH-1:0] delta;
  logic                 gray_err;
  logic                 err_sticky;

  modport master (
    output grey_in, grey_valid, err_clr,
    input  binary_out, binary_valid, delta, gray_err, err_sticky
  );

  modport slave (
    input  grey_in, grey_valid, err_clr,
    output binary_out, binary_valid, delta, gray_err, err_sticky
  );
endinterface

// File: rtl/grey_ptr_decoder_dec.sv
// Combinational Gray-to-binary slice. seed is the already-decoded binary
// bit just above this slice (0 for the top slice), so a word can be
// decoded in pieces across pipeline stages.
module grey_ptr_decoder_dec
  import grey_ptr_decoder_pkg::*;
#(
  parameter int W = PTR_WIDTH_DEF
) (
  input  logic [W-1:0] grey,
  input  logic         seed,
  output logic [W-1:0] bin
);
  // Each bit is the XOR of all Gray bits at and above it, plus the seed.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = seed ^ (^grey[W-1:i]);
  end
endmodule

// File: rtl/grey_ptr_decoder.sv
// Receive-side Gray pointer decoder: registered Gray-to-binary decode
// (1 or 2 stages), pointer advance (delta) and illegal-transition flag.
// Optional build macro: GREY_DEC_ERR_CHECK_EN enables the Hamming check,
// gray_err and err_sticky; without it both outputs are tied low.
module grey_ptr_decoder
  import grey_ptr_decoder_pkg::*;
#(
  parameter int PTR_WIDTH   = PTR_WIDTH_DEF,
  parameter int PIPE_STAGES = 1
) (
  input logic              clk,
  input logic              rst,
  grey_ptr_decoder_if.slave bus
);
  localparam int HI_W = (PTR_WIDTH + 1) / 2;
  localparam int LO_W = PTR_WIDTH - HI_W;

  if (!stages_legal(PIPE_STAGES)) begin : g_bad_stages
    $fatal(1, "grey_ptr_decoder: PIPE_STAGES must be 1 or 2");
  end

  logic                   have_prev;
  logic [PIPE_STAGES:1]   vld_pipe;
  logic                   f_vld;
  logic                   f_first;
  logic [PTR_WIDTH-1:0]   f_bin;
  logic [PTR_WIDTH-1:0]   bin_q;
  logic [PTR_WIDTH-1:0]   delta_q;

  // Remember whether any valid sample has been seen since reset.
  always_ff @(posedge clk) begin
    if (rst)                 have_prev <= 1'b0;
    else if (bus.grey_valid) have_prev <= 1'b1;
  end

  // Valid shift register; reset drops every in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= bus.grey_valid;
      for (int i = 2; i <= PIPE_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // f_* is what the output register captures at the next edge.
  if (PIPE_STAGES == 1) begin : g_p1
    grey_ptr_decoder_dec #(.W(PTR_WIDTH)) u_dec (
      .grey (bus.grey_in),
      .seed (1'b0),
      .bin  (f_bin)
    );
    assign f_vld   = bus.grey_valid;
    assign f_first = ~have_prev;
  end else begin : g_p2
    logic [HI_W-1:0] hi_bin;
    logic [HI_W-1:0] s1_hi;
    logic [LO_W-1:0] s1_lo;
    logic [LO_W-1:0] lo_bin;
    logic            s1_first;

    grey_ptr_decoder_dec #(.W(HI_W)) u_hi (
      .grey (bus.grey_in[PTR_WIDTH-1:LO_W]),
      .seed (1'b0),
      .bin  (hi_bin)
    );

    // Stage 1: decoded upper half, raw lower Gray bits, first-sample tag.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_hi    <= '0;
        s1_lo    <= '0;
        s1_first <= 1'b0;
      end else if (bus.grey_valid) begin
        s1_hi    <= hi_bin;
        s1_lo    <= bus.grey_in[LO_W-1:0];
        s1_first <= ~have_prev;
      end
    end

    // Stage 2 seeds the lower chain from the lowest decoded upper bit.
    grey_ptr_decoder_dec #(.W(LO_W)) u_lo (
      .grey (s1_lo),
      .seed (s1_hi[0]),
      .bin  (lo_bin)
    );
    assign f_bin   = {s1_hi, lo_bin};
    assign f_vld   = vld_pipe[1];
    assign f_first = s1_first;
  end

  // Output register; bin_q doubles as the previous decoded pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      delta_q <= '0;
    end else if (f_vld) begin
      bin_q   <= f_bin;
      delta_q <= f_first ? '0 : f_bin - bin_q;
    end
  end

  assign bus.binary_out   = bin_q;
  assign bus.delta        = delta_q;
  assign bus.binary_valid = vld_pipe[PIPE_STAGES];

`ifdef GREY_DEC_ERR_CHECK_EN
  logic [PTR_WIDTH-1:0] prev_grey;
  logic                 err0;
  logic                 f_err;
  logic [PIPE_STAGES:1] err_pipe;
  logic                 sticky_q;

  assign err0 = bus.grey_valid & have_prev &
                (popcount(32'(bus.grey_in ^ prev_grey)) > 1);
  assign f_err = (PIPE_STAGES == 1) ? err0 : err_pipe[1];

  // Last valid Gray sample, compared against the next one.
  always_ff @(posedge clk) begin
    if (rst)                 prev_grey <= '0;
    else if (bus.grey_valid) prev_grey <= bus.grey_in;
  end

  // Error travels alongside its sample so it lines up with binary_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pipe <= '0;
    end else begin
      err_pipe[1] <= err0;
      for (int i = 2; i <= PIPE_STAGES; i++) err_pipe[i] <= err_pipe[i-1];
    end
  end

  // Sticky error: a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)              sticky_q <= 1'b0;
    else if (f_err)       sticky_q <= 1'b1;
    else if (bus.err_clr) sticky_q <= 1'b0;
  end

  assign bus.gray_err   = err_pipe[PIPE_STAGES];
  assign bus.err_sticky = sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.gray_err   = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_grey_ptr_decoder.sv
// Directed bench for grey_ptr_decoder: one instance per pipeline depth.
module tb_grey_ptr_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef GREY_DEC_ERR_CHECK_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  grey_ptr_decoder_if #(.PTR_WIDTH(5)) if1 ();
  grey_ptr_decoder_if #(.PTR_WIDTH(5)) if2 ();

  grey_ptr_decoder #(.PTR_WIDTH(5), .PIPE_STAGES(1)) u_p1 (
    .clk (clk), .rst (rst1), .bus (if1)
  );
  grey_ptr_decoder #(.PTR_WIDTH(5), .PIPE_STAGES(2)) u_p2 (
    .clk (clk), .rst (rst2), .bus (if2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step1(input logic [4:0] g, input logic v, input logic clr);
    if1.grey_in = g; if1.grey_valid = v; if1.err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic [4:0] g, input logic v);
    if2.grey_in = g; if2.grey_valid = v; if2.err_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic out1(input string t, input logic [4:0] b, input logic v,
                      input logic [4:0] d, input logic er, input logic st);
    chk({t, ".bin"},    32'(if1.binary_out),   32'(b));
    chk({t, ".vld"},    32'(if1.binary_valid), 32'(v));
    chk({t, ".delta"},  32'(if1.delta),        32'(d));
    chk({t, ".err"},    32'(if1.gray_err),     32'(er));
    chk({t, ".sticky"}, 32'(if1.err_sticky),   32'(st));
  endtask

  task automatic out2(input string t, input logic [4:0] b, input logic v,
                      input logic [4:0] d);
    chk({t, ".bin"},    32'(if2.binary_out),   32'(b));
    chk({t, ".vld"},    32'(if2.binary_valid), 32'(v));
    chk({t, ".delta"},  32'(if2.delta),        32'(d));
    chk({t, ".err"},    32'(if2.gray_err),     32'(0));
    chk({t, ".sticky"}, 32'(if2.err_sticky),   32'(0));
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    step1(5'd0, 1'b0, 1'b0);
    rst1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    if1.grey_in = '0; if1.grey_valid = 1'b0; if1.err_clr = 1'b0;
    if2.grey_in = '0; if2.grey_valid = 1'b0; if2.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out1("rst1", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    out2("rst2", 5'd0, 1'b0, 5'd0);
    rst1 = 1'b0; rst2 = 1'b0;

    // Consecutive pointer values 0..3
    step1(5'b00000, 1'b1, 1'b0); out1("seq0", 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    step1(5'b00001, 1'b1, 1'b0); out1("seq1", 5'd1, 1'b1, 5'd1, 1'b0, 1'b0);
    step1(5'b00011, 1'b1, 1'b0); out1("seq2", 5'd2, 1'b1, 5'd1, 1'b0, 1'b0);
    step1(5'b00010, 1'b1, 1'b0); out1("seq3", 5'd3, 1'b1, 5'd1, 1'b0, 1'b0);

    // Wrap 30 -> 31 -> 0
    reset1();
    out1("rstw", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step1(5'b10001, 1'b1, 1'b0); out1("wrap30", 5'd30, 1'b1, 5'd0, 1'b0, 1'b0);
    step1(5'b10000, 1'b1, 1'b0); out1("wrap31", 5'd31, 1'b1, 5'd1, 1'b0, 1'b0);
    step1(5'b00000, 1'b1, 1'b0); out1("wrap0",  5'd0,  1'b1, 5'd1, 1'b0, 1'b0);

    // Illegal jump 1 -> 4, sticky behaviour, clear vs. new error
    reset1();
    step1(5'b00001, 1'b1, 1'b0); out1("ill1",   5'd1, 1'b1, 5'd0,  1'b0, 1'b0);
    step1(5'b00110, 1'b1, 1'b0); out1("ill4",   5'd4, 1'b1, 5'd3,  E,    E);
    step1(5'b00110, 1'b0, 1'b0); out1("illhld", 5'd4, 1'b0, 5'd3,  1'b0, E);
    step1(5'b00000, 1'b0, 1'b1); out1("illclr", 5'd4, 1'b0, 5'd3,  1'b0, 1'b0);
    step1(5'b00001, 1'b1, 1'b1); out1("illset", 5'd1, 1'b1, 5'd29, E,    E);
    step1(5'b00000, 1'b0, 1'b0); out1("illpst", 5'd1, 1'b0, 5'd29, 1'b0, E);

    // Valid gaps: 5, gap, gap, 6, repeat 6
    reset1();
    step1(5'b00111, 1'b1, 1'b0); out1("gap5",  5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    step1(5'b11111, 1'b0, 1'b0); out1("gapa",  5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step1(5'b11000, 1'b0, 1'b0); out1("gapb",  5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step1(5'b00101, 1'b1, 1'b0); out1("gap6",  5'd6, 1'b1, 5'd1, 1'b0, 1'b0);
    step1(5'b00101, 1'b1, 1'b0); out1("rep6",  5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
    step1(5'b00000, 1'b0, 1'b0);

    // Two-stage pipeline, reset mid-stream
    step2(5'b00000, 1'b1); out2("p2s0", 5'd0, 1'b0, 5'd0);
    step2(5'b00001, 1'b1); out2("p2s1", 5'd0, 1'b1, 5'd0);
    step2(5'b00011, 1'b1); out2("p2s2", 5'd1, 1'b1, 5'd1);
    step2(5'b00010, 1'b1); out2("p2s3", 5'd2, 1'b1, 5'd1);
    rst2 = 1'b1;
    step2(5'b00110, 1'b1); out2("p2rst", 5'd0, 1'b0, 5'd0);
    rst2 = 1'b0;
    step2(5'b00000, 1'b0); out2("p2idl1", 5'd0, 1'b0, 5'd0);
    step2(5'b00000, 1'b0); out2("p2idl2", 5'd0, 1'b0, 5'd0);
    step2(5'b01010, 1'b1); out2("p2lat1", 5'd0,  1'b0, 5'd0);
    step2(5'b00000, 1'b0); out2("p2s12",  5'd12, 1'b1, 5'd0);
    step2(5'b00000, 1'b0); out2("p2hold", 5'd12, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
